// File: rtl/pulse_pkg.sv
// Shared constants for the pulse deserializer: default frame width, FSM
// state encodings and the ones-count width.
package pulse_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned ONES_W        = $clog2(DEFAULT_WIDTH) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

endpackage

// File: rtl/pulse_bit_counter.sv
// Bit-position counter for the deserializer: load to 1 on a frame start,
// increment per shifted bit, flag the cycle that carries the final data bit.
module pulse_bit_counter #(
  parameter int unsigned CNT_W = 5,
  parameter int unsigned TERM  = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             last_bit_c
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
    end else if (load) begin
      bit_cnt <= CNT_W'(1);
    end else if (inc) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign last_bit_c = (bit_cnt == CNT_W'(TERM));

endmodule

// File: rtl/pulse_deserializer.sv
// MSB-first serial-to-parallel deserializer with abort-on-restart and a
// registered ones count. Define PULSE_DESER_PARITY_EN for a trailing even-parity bit.
module pulse_deserializer
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   serial_in,
  input  logic                   frame_start,
  output logic [WIDTH-1:0]       word_out,
  output logic                   word_valid,
  output logic [$clog2(WIDTH):0] ones_count,
  output logic                   busy,
  output logic                   frame_abort,
  output logic                   parity_err
);

  localparam int unsigned OW    = $clog2(WIDTH) + 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef PULSE_DESER_PARITY_EN
  localparam int unsigned SH_W  = WIDTH;
`else
  // the final data bit comes straight from serial_in, so one bit less is stored
  localparam int unsigned SH_W  = WIDTH - 1;
`endif

  logic [1:0]       state, state_n;
  logic [SH_W-1:0]  shreg, shreg_n;
  logic [WIDTH-1:0] word_n, done_word;
  logic [OW-1:0]    ones_n, ones_c;
  logic             valid_n, abort_n;
  logic             cnt_load, cnt_inc, last_bit_c;
  logic [CNT_W-1:0] bit_cnt;
  logic             unused_bit_cnt;

  pulse_bit_counter #(
    .CNT_W (CNT_W),
    .TERM  (WIDTH - 1)
  ) u_bit_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .inc        (cnt_inc),
    .bit_cnt    (bit_cnt),
    .last_bit_c (last_bit_c)
  );

  // bit position is carried for observability; sequencing uses last_bit_c
  assign unused_bit_cnt = ^bit_cnt;

  // Word as it stands when a frame completes on this edge
`ifdef PULSE_DESER_PARITY_EN
  assign done_word = (state == PARITY) ? shreg : WIDTH'({shreg, serial_in});
`else
  assign done_word = {shreg, serial_in};
`endif

  always_comb begin
    ones_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) ones_c = ones_c + OW'(done_word[i]);
  end

`ifdef PULSE_DESER_PARITY_EN
  logic perr_n;
`endif

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    word_n   = word_out;
    ones_n   = ones_count;
    valid_n  = 1'b0;
    abort_n  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
`ifdef PULSE_DESER_PARITY_EN
    perr_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (frame_start) begin
          shreg_n  = SH_W'(serial_in);
          cnt_load = 1'b1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          abort_n  = 1'b1;
          shreg_n  = SH_W'(serial_in);
          cnt_load = 1'b1;
        end else begin
          shreg_n = SH_W'({shreg, serial_in});
          cnt_inc = 1'b1;
          if (last_bit_c) begin
`ifdef PULSE_DESER_PARITY_EN
            state_n = PARITY;
`else
            word_n  = done_word;
            ones_n  = ones_c;
            valid_n = 1'b1;
            state_n = IDLE;
`endif
          end
        end
      end
`ifdef PULSE_DESER_PARITY_EN
      PARITY: begin
        if (frame_start) begin
          abort_n  = 1'b1;
          shreg_n  = SH_W'(serial_in);
          cnt_load = 1'b1;
          state_n  = SHIFT;
        end else begin
          word_n  = done_word;
          ones_n  = ones_c;
          valid_n = 1'b1;
          perr_n  = ^{shreg, serial_in};
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      word_out    <= '0;
      ones_count  <= '0;
      word_valid  <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      word_out    <= word_n;
      ones_count  <= ones_n;
      word_valid  <= valid_n;
      frame_abort <= abort_n;
      busy        <= (state_n != IDLE);
    end
  end

`ifdef PULSE_DESER_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) parity_err <= 1'b0;
    else          parity_err <= perr_n;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_deserializer.sv
// Self-checking bench for pulse_deserializer; the reference model works on
// whole words (popcount, parity, expected pulse counts) rather than cycles.
module tb_pulse_deserializer;

  localparam int unsigned W  = 16;
  localparam int unsigned OW = 5;
`ifdef PULSE_DESER_PARITY_EN
  localparam bit          PAR = 1'b1;
  localparam int unsigned FL  = W + 1;
`else
  localparam bit          PAR = 1'b0;
  localparam int unsigned FL  = W;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          serial_in = 1'b0;
  logic          frame_start = 1'b0;
  logic [W-1:0]  word_out;
  logic          word_valid;
  logic [OW-1:0] ones_count;
  logic          busy;
  logic          frame_abort;
  logic          parity_err;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_abort = 0;
  int n_perr  = 0;

  pulse_deserializer #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .serial_in   (serial_in),
    .frame_start (frame_start),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .ones_count  (ones_count),
    .busy        (busy),
    .frame_abort (frame_abort),
    .parity_err  (parity_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (word_valid)  n_valid++;
    if (frame_abort) n_abort++;
    if (parity_err)  n_perr++;
  end

  function automatic logic [OW-1:0] ref_ones(input logic [W-1:0] w);
    int c = 0;
    for (int i = 0; i < int'(W); i++) c += int'(w[i]);
    return OW'(c);
  endfunction

  function automatic logic even_bit(input logic [W-1:0] w);
    int c = 0;
    for (int i = 0; i < int'(W); i++) c += int'(w[i]);
    return logic'(c % 2);
  endfunction

  task automatic send_bit(input logic b, input logic fs);
    serial_in   = b;
    frame_start = fs;
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic p);
    for (int i = int'(W) - 1; i >= 0; i--) send_bit(w[i], logic'(i == int'(W) - 1));
    if (PAR) send_bit(p, 1'b0);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    total++; if (word_out !== '0)     begin bad++; $display("FAIL reset_word got=%h exp=0", word_out); end
    total++; if (ones_count !== '0)   begin bad++; $display("FAIL reset_ones got=%0d exp=0", ones_count); end
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (frame_abort !== 1'b0) begin bad++; $display("FAIL reset_abort got=%b exp=0", frame_abort); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] w = 16'h5254;
    logic [W:0]   bits = {w, even_bit(w)};
    for (int i = 0; i < int'(FL); i++) begin
      send_bit(bits[W - i], logic'(i == 0));
      if (i < int'(FL) - 1) begin
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid cyc=%0d got=%b exp=0", i, word_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy cyc=%0d got=%b exp=1", i, busy); end
      end
    end
    frame_start = 1'b0;
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", word_valid); end
    total++; if (word_out !== w) begin bad++; $display("FAIL single_word got=%h exp=%h", word_out, w); end
    total++; if (ones_count !== OW'(6)) begin bad++; $display("FAIL single_ones got=%0d exp=6", ones_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    send_bit(1'b1, 1'b0);
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_width got=%b exp=0", word_valid); end
    total++; if (word_out !== w) begin bad++; $display("FAIL single_hold got=%h exp=%h", word_out, w); end
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    int a0 = n_abort;
    send_frame(16'hFFFF, even_bit(16'hFFFF));
    total++; if (ones_count !== OW'(16)) begin bad++; $display("FAIL b2b_ones_ffff got=%0d exp=16", ones_count); end
    send_bit(1'b0, 1'b0);
    send_frame(16'h0000, 1'b0);
    total++; if (word_out !== 16'h0000) begin bad++; $display("FAIL b2b_word0 got=%h exp=0000", word_out); end
    total++; if (ones_count !== OW'(0)) begin bad++; $display("FAIL b2b_ones0 got=%0d exp=0", ones_count); end
    // second frame starts right on the cycle after the previous frame ends
    send_frame(16'h8001, even_bit(16'h8001));
    send_frame(16'h7FFE, even_bit(16'h7FFE));
    total++; if (word_out !== 16'h7FFE) begin bad++; $display("FAIL b2b_nogap_word got=%h exp=7ffe", word_out); end
    send_bit(1'b0, 1'b0);
    total++; if (n_valid - v0 != 4) begin bad++; $display("FAIL b2b_valid_count got=%0d exp=4", n_valid - v0); end
    total++; if (n_abort != a0) begin bad++; $display("FAIL b2b_abort_count got=%0d exp=0", n_abort - a0); end
  endtask

  task automatic test_abort();
    logic [W-1:0] junk = 16'hA5A5;
    logic [W-1:0] prev;
    int v0, a0;
    send_bit(1'b0, 1'b0);
    prev = word_out;
    v0 = n_valid;
    a0 = n_abort;
    for (int i = 0; i < 9; i++) send_bit(junk[int'(W) - 1 - i], logic'(i == 0));
    send_bit(1'b0, 1'b1);
    total++; if (frame_abort !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%b exp=1", frame_abort); end
    total++; if (word_out !== prev) begin bad++; $display("FAIL abort_word_hold got=%h exp=%h", word_out, prev); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy got=%b exp=1", busy); end
    for (int i = int'(W) - 2; i >= 0; i--) send_bit(logic'((16'h1234 >> i) & 1), 1'b0);
    if (PAR) send_bit(even_bit(16'h1234), 1'b0);
    total++; if (word_out !== 16'h1234) begin bad++; $display("FAIL abort_word got=%h exp=1234", word_out); end
    total++; if (ones_count !== OW'(5)) begin bad++; $display("FAIL abort_ones got=%0d exp=5", ones_count); end
    send_bit(1'b0, 1'b0);
    total++; if (n_abort - a0 != 1) begin bad++; $display("FAIL abort_count got=%0d exp=1", n_abort - a0); end
    total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL abort_valid_count got=%0d exp=1", n_valid - v0); end
    // restart on the very last bit slot of a frame
    a0 = n_abort;
    v0 = n_valid;
    for (int i = 0; i < int'(FL) - 1; i++) send_bit(1'b1, logic'(i == 0));
    send_frame(16'h0F0F, even_bit(16'h0F0F));
    send_bit(1'b0, 1'b0);
    total++; if (n_abort - a0 != 1) begin bad++; $display("FAIL abort_last_count got=%0d exp=1", n_abort - a0); end
    total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL abort_last_valid got=%0d exp=1", n_valid - v0); end
    total++; if (word_out !== 16'h0F0F) begin bad++; $display("FAIL abort_last_word got=%h exp=0f0f", word_out); end
  endtask

  task automatic test_reset_mid();
    int v0 = n_valid;
    int a0 = n_abort;
    for (int i = 0; i < 7; i++) send_bit(1'b1, logic'(i == 0));
    frame_start = 1'b0;
    reset_n = 1'b0;
    #1;
    total++; if (word_out !== '0) begin bad++; $display("FAIL rstmid_word got=%h exp=0", word_out); end
    total++; if (ones_count !== '0) begin bad++; $display("FAIL rstmid_ones got=%0d exp=0", ones_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b1;
    send_frame(16'h00FF, even_bit(16'h00FF));
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL rstmid_valid got=%b exp=1", word_valid); end
    total++; if (ones_count !== OW'(8)) begin bad++; $display("FAIL rstmid_ones8 got=%0d exp=8", ones_count); end
    total++; if (word_out !== 16'h00FF) begin bad++; $display("FAIL rstmid_word_ff got=%h exp=00ff", word_out); end
    send_bit(1'b0, 1'b0);
    total++; if (n_abort != a0) begin bad++; $display("FAIL rstmid_abort got=%0d exp=0", n_abort - a0); end
    total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL rstmid_valid_count got=%0d exp=1", n_valid - v0); end
  endtask

  task automatic test_idle();
    logic [W-1:0]  w0 = word_out;
    logic [OW-1:0] o0 = ones_count;
    int v0 = n_valid;
    int a0 = n_abort;
    for (int i = 0; i < 40; i++) begin
      send_bit(logic'($urandom_range(0, 1)), 1'b0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy cyc=%0d got=%b exp=0", i, busy); end
    end
    total++; if (word_out !== w0) begin bad++; $display("FAIL idle_word got=%h exp=%h", word_out, w0); end
    total++; if (ones_count !== o0) begin bad++; $display("FAIL idle_ones got=%0d exp=%0d", ones_count, o0); end
    total++; if (n_valid != v0 || n_abort != a0) begin bad++; $display("FAIL idle_pulses got=%0d/%0d exp=0/0", n_valid - v0, n_abort - a0); end
  endtask

  task automatic test_parity();
    int p0 = n_perr;
    send_frame(16'h0001, 1'b0);
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL par_valid got=%b exp=1", word_valid); end
    total++; if (parity_err !== PAR) begin bad++; $display("FAIL par_err_bad got=%b exp=%b", parity_err, PAR); end
    send_bit(1'b0, 1'b0);
    send_frame(16'h0001, 1'b1);
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL par_valid2 got=%b exp=1", word_valid); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_err_good got=%b exp=0", parity_err); end
    send_bit(1'b0, 1'b0);
    total++; if (n_perr - p0 != int'(PAR)) begin bad++; $display("FAIL par_err_count got=%0d exp=%0d", n_perr - p0, int'(PAR)); end
  endtask

  task automatic test_random();
    int v0 = n_valid;
    int a0 = n_abort;
    int exp_abort = 0;
    for (int f = 0; f < 40; f++) begin
      logic [W-1:0] w = W'($urandom);
      logic flip = ($urandom_range(0, 3) == 0);
      logic exp_perr = PAR & flip;
      if ($urandom_range(0, 3) == 0) begin
        int k = $urandom_range(1, int'(FL) - 1);
        for (int i = 0; i < k; i++) send_bit(logic'($urandom_range(0, 1)), logic'(i == 0));
        exp_abort++;
      end
      send_frame(w, even_bit(w) ^ flip);
      total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL rnd_valid f=%0d got=%b exp=1", f, word_valid); end
      total++; if (word_out !== w) begin bad++; $display("FAIL rnd_word f=%0d got=%h exp=%h", f, word_out, w); end
      total++; if (ones_count !== ref_ones(w)) begin bad++; $display("FAIL rnd_ones f=%0d got=%0d exp=%0d", f, ones_count, ref_ones(w)); end
      total++; if (parity_err !== exp_perr) begin bad++; $display("FAIL rnd_perr f=%0d got=%b exp=%b", f, parity_err, exp_perr); end
      repeat ($urandom_range(0, 2)) send_bit(logic'($urandom_range(0, 1)), 1'b0);
    end
    send_bit(1'b0, 1'b0);
    total++; if (n_valid - v0 != 40) begin bad++; $display("FAIL rnd_valid_count got=%0d exp=40", n_valid - v0); end
    total++; if (n_abort - a0 != exp_abort) begin bad++; $display("FAIL rnd_abort_count got=%0d exp=%0d", n_abort - a0, exp_abort); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_idle();
    test_parity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
